// File: rtl/ahb_slave_mux_if.sv
// Data-phase response bundle between the address decoder / slaves and the AHB slave mux.
// The slave modport is the mux's view; the master modport drives selects and slave responses.
interface ahb_slave_mux_if #(
    parameter int DW = 32
);
    logic          s0_HSEL;
    logic          s1_HSEL;
    logic          s2_HSEL;
    logic          s3_HSEL;
    logic          s4_HSEL;
    logic          s5_HSEL;
    logic          s6_HSEL;
    logic [1:0]    HTRANS;
    logic [DW-1:0] s0_HRDATA;
    logic [DW-1:0] s1_HRDATA;
    logic [DW-1:0] s2_HRDATA;
    logic [DW-1:0] s3_HRDATA;
    logic [DW-1:0] s4_HRDATA;
    logic [DW-1:0] s5_HRDATA;
    logic [DW-1:0] s6_HRDATA;
    logic          s0_HREADYOUT;
    logic          s1_HREADYOUT;
    logic          s2_HREADYOUT;
    logic          s3_HREADYOUT;
    logic          s4_HREADYOUT;
    logic          s5_HREADYOUT;
    logic          s6_HREADYOUT;
    logic          s0_HRESP;
    logic          s1_HRESP;
    logic          s2_HRESP;
    logic          s3_HRESP;
    logic          s4_HRESP;
    logic          s5_HRESP;
    logic          s6_HRESP;
    logic [DW-1:0] HRDATA;
    logic          HREADY;
    logic          HRESP;

    modport slave (
        input  s0_HSEL, s1_HSEL, s2_HSEL, s3_HSEL, s4_HSEL, s5_HSEL, s6_HSEL,
        input  HTRANS,
        input  s0_HRDATA, s1_HRDATA, s2_HRDATA, s3_HRDATA, s4_HRDATA, s5_HRDATA, s6_HRDATA,
        input  s0_HREADYOUT, s1_HREADYOUT, s2_HREADYOUT, s3_HREADYOUT,
        input  s4_HREADYOUT, s5_HREADYOUT, s6_HREADYOUT,
        input  s0_HRESP, s1_HRESP, s2_HRESP, s3_HRESP, s4_HRESP, s5_HRESP, s6_HRESP,
        output HRDATA, HREADY, HRESP
    );

    modport master (
        output s0_HSEL, s1_HSEL, s2_HSEL, s3_HSEL, s4_HSEL, s5_HSEL, s6_HSEL,
        output HTRANS,
        output s0_HRDATA, s1_HRDATA, s2_HRDATA, s3_HRDATA, s4_HRDATA, s5_HRDATA, s6_HRDATA,
        output s0_HREADYOUT, s1_HREADYOUT, s2_HREADYOUT, s3_HREADYOUT,
        output s4_HREADYOUT, s5_HREADYOUT, s6_HREADYOUT,
        output s0_HRESP, s1_HRESP, s2_HRESP, s3_HRESP, s4_HRESP, s5_HRESP, s6_HRESP,
        input  HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_slave_mux.sv
// AHB-Lite data-phase response mux for seven slaves plus a built-in default slave
// that answers unmapped addresses with a two-cycle ERROR.
module ahb_slave_mux #(
    parameter int            DW            = 32,
    parameter logic [DW-1:0] DEFAULT_RDATA = '0
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    ahb_slave_mux_if.slave   bus
);
    localparam int NS = 7;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_ERR1 = 2'd1,
        D_ERR2 = 2'd2
    } dstate_e;

    logic [NS-1:0] w_hsel;
    logic [NS-1:0] w_rdy;
    logic [NS-1:0] w_resp;
    logic [DW-1:0] w_rdata [NS];
    logic [NS:0]   w_addr_sel;
    logic [NS:0]   r_dsel;
    dstate_e       r_state;
    dstate_e       w_next;
    logic          w_start;
    logic          w_def_ready;
    logic          w_def_resp;
    logic [DW-1:0] w_hrdata;
    logic          w_hready;
    logic          w_hresp;
    logic          w_unused_htrans0;

    assign w_hsel = {bus.s6_HSEL, bus.s5_HSEL, bus.s4_HSEL, bus.s3_HSEL,
                     bus.s2_HSEL, bus.s1_HSEL, bus.s0_HSEL};
    assign w_rdy  = {bus.s6_HREADYOUT, bus.s5_HREADYOUT, bus.s4_HREADYOUT, bus.s3_HREADYOUT,
                     bus.s2_HREADYOUT, bus.s1_HREADYOUT, bus.s0_HREADYOUT};
    assign w_resp = {bus.s6_HRESP, bus.s5_HRESP, bus.s4_HRESP, bus.s3_HRESP,
                     bus.s2_HRESP, bus.s1_HRESP, bus.s0_HRESP};

    assign w_rdata[0] = bus.s0_HRDATA;
    assign w_rdata[1] = bus.s1_HRDATA;
    assign w_rdata[2] = bus.s2_HRDATA;
    assign w_rdata[3] = bus.s3_HRDATA;
    assign w_rdata[4] = bus.s4_HRDATA;
    assign w_rdata[5] = bus.s5_HRDATA;
    assign w_rdata[6] = bus.s6_HRDATA;

    assign w_unused_htrans0 = bus.HTRANS[0];

    // Illegal multi-select resolves to the lowest index: scan downward so it is written last.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_addr_sel     = '0;
        w_addr_sel[NS] = 1'b1;
        for (int i = NS - 1; i >= 0; i--) begin
            if (w_hsel[i]) begin
                w_addr_sel    = '0;
                w_addr_sel[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_dsel <= {1'b1, {NS{1'b0}}};
        end else if (w_hready) begin
            r_dsel <= w_addr_sel;
        end
    end

    assign w_def_ready = (r_state != D_ERR1);
    assign w_def_resp  = (r_state != D_IDLE);
    assign w_start     = w_hready & ~(|w_hsel) & bus.HTRANS[1];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= D_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = D_IDLE;
        case (r_state)
            D_IDLE:  w_next = w_start ? D_ERR1 : D_IDLE;
            D_ERR1:  w_next = D_ERR2;
            D_ERR2:  w_next = w_start ? D_ERR1 : D_IDLE;
            default: w_next = D_IDLE;
        endcase
    end

    // dsel is one-hot, so at most one slave override fires; otherwise the default slave answers.
    always_comb begin
        w_hrdata = DEFAULT_RDATA;
        w_hready = w_def_ready;
        w_hresp  = w_def_resp;
        for (int i = 0; i < NS; i++) begin
            if (r_dsel[i]) begin
                w_hrdata = w_rdata[i];
                w_hready = w_rdy[i];
                w_hresp  = w_resp[i];
            end
        end
    end

    assign bus.HRDATA = w_hrdata;
    assign bus.HREADY = w_hready;
    assign bus.HRESP  = w_hresp;
endmodule

// File: tb/tb_ahb_slave_mux.sv
// Self-checking bench for ahb_slave_mux: directed scenarios followed by random traffic,
// compared against a transaction-level model of data-phase ownership.
module tb_ahb_slave_mux;
    localparam int          DW   = 32;
    localparam logic [31:0] DEF  = 32'hDEAD_0BAD;
    localparam logic [1:0]  IDLE = 2'b00;
    localparam logic [1:0]  BUSY = 2'b01;
    localparam logic [1:0]  NSEQ = 2'b10;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    ahb_slave_mux_if #(.DW(DW)) bus ();

    ahb_slave_mux #(.DW(DW), .DEFAULT_RDATA(DEF)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    logic [6:0]  t_hsel;
    logic [1:0]  t_htrans;
    logic [31:0] t_rdata [7];
    logic [6:0]  t_rdy;
    logic [6:0]  t_resp;

    assign bus.s0_HSEL = t_hsel[0];
    assign bus.s1_HSEL = t_hsel[1];
    assign bus.s2_HSEL = t_hsel[2];
    assign bus.s3_HSEL = t_hsel[3];
    assign bus.s4_HSEL = t_hsel[4];
    assign bus.s5_HSEL = t_hsel[5];
    assign bus.s6_HSEL = t_hsel[6];
    assign bus.HTRANS  = t_htrans;
    assign bus.s0_HRDATA = t_rdata[0];
    assign bus.s1_HRDATA = t_rdata[1];
    assign bus.s2_HRDATA = t_rdata[2];
    assign bus.s3_HRDATA = t_rdata[3];
    assign bus.s4_HRDATA = t_rdata[4];
    assign bus.s5_HRDATA = t_rdata[5];
    assign bus.s6_HRDATA = t_rdata[6];
    assign bus.s0_HREADYOUT = t_rdy[0];
    assign bus.s1_HREADYOUT = t_rdy[1];
    assign bus.s2_HREADYOUT = t_rdy[2];
    assign bus.s3_HREADYOUT = t_rdy[3];
    assign bus.s4_HREADYOUT = t_rdy[4];
    assign bus.s5_HREADYOUT = t_rdy[5];
    assign bus.s6_HREADYOUT = t_rdy[6];
    assign bus.s0_HRESP = t_resp[0];
    assign bus.s1_HRESP = t_resp[1];
    assign bus.s2_HRESP = t_resp[2];
    assign bus.s3_HRESP = t_resp[3];
    assign bus.s4_HRESP = t_resp[4];
    assign bus.s5_HRESP = t_resp[5];
    assign bus.s6_HRESP = t_resp[6];

    int n_checks = 0;
    int n_fail   = 0;

    // Model: who owns the current data phase (0..6 = slave, 7 = default) and how far
    // into a default-slave ERROR we are (0 = none, 1 = first cycle, 2 = second cycle).
    int m_owner = 7;
    int m_phase = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] decode(input logic [31:0] addr);
        int region;
        region = int'(addr[31:28]);
        decode = '0;
        if (region < 7) decode[region] = 1'b1;
    endfunction

    task automatic addr_phase(input logic [31:0] addr, input logic [1:0] trans);
        t_hsel   = decode(addr);
        t_htrans = trans;
    endtask

    task automatic no_transfer();
        t_hsel   = '0;
        t_htrans = IDLE;
    endtask

    // One bus cycle: check the data-phase outputs mid-cycle, then advance the model at the edge.
    task automatic step(input string tag, input int lit_ready = -1, input int lit_resp = -1);
        logic [31:0] e_rdata;
        logic        e_ready;
        logic        e_resp;
        int          own;
        @(negedge HCLK);
        if (m_owner < 7) begin
            e_rdata = t_rdata[m_owner];
            e_ready = t_rdy[m_owner];
            e_resp  = t_resp[m_owner];
        end else begin
            e_rdata = DEF;
            e_ready = (m_phase != 1);
            e_resp  = (m_phase != 0);
        end
        check({tag, " HRDATA"}, bus.HRDATA, e_rdata);
        check({tag, " HREADY"}, {31'd0, bus.HREADY}, {31'd0, e_ready});
        check({tag, " HRESP"},  {31'd0, bus.HRESP},  {31'd0, e_resp});
        if (lit_ready >= 0) check({tag, " HREADY lit"}, {31'd0, bus.HREADY}, 32'(lit_ready));
        if (lit_resp >= 0)  check({tag, " HRESP lit"},  {31'd0, bus.HRESP},  32'(lit_resp));
        @(posedge HCLK);
        if (e_ready) begin
            own = 7;
            for (int i = 6; i >= 0; i--) if (t_hsel[i]) own = i;
            m_owner = own;
            m_phase = (own == 7 && t_htrans[1]) ? 1 : 0;
        end else if (m_owner == 7 && m_phase == 1) begin
            m_phase = 2;
        end
        #1;
    endtask

    initial begin
        no_transfer();
        t_rdy  = '1;
        t_resp = '0;
        for (int i = 0; i < 7; i++) t_rdata[i] = 32'hC0DE_0000 | 32'(i);

        // Reset values
        #2;
        check("reset HRDATA", bus.HRDATA, DEF);
        check("reset HREADY", {31'd0, bus.HREADY}, 32'd1);
        check("reset HRESP",  {31'd0, bus.HRESP},  32'd0);
        #10 HRESETn = 1'b1;
        @(posedge HCLK);
        #1;

        // Simple read from s1
        t_rdata[1] = 32'hA5A5_0001;
        addr_phase(32'h1000_0010, NSEQ);
        step("s1 addr", 1, 0);
        no_transfer();
        step("s1 data", 1, 0);

        // s2 with three wait states while the master holds a new address to s0
        addr_phase(32'h2000_0000, NSEQ);
        step("s2 addr", 1, 0);
        addr_phase(32'h0000_0000, NSEQ);
        t_rdata[0] = 32'h0000_5A5A;
        t_rdata[2] = 32'h2222_2222;
        t_rdy[2]   = 1'b0;
        step("s2 wait1", 0, -1);
        step("s2 wait2", 0, -1);
        step("s2 wait3", 0, -1);
        t_rdy[2] = 1'b1;
        step("s2 done", 1, 0);
        no_transfer();
        step("s0 data", 1, 0);

        // Unmapped NONSEQ: two-cycle ERROR from the default slave
        addr_phase(32'h9000_0000, NSEQ);
        step("unm addr", 1, 0);
        no_transfer();
        step("unm err1", 0, 1);
        step("unm err2", 1, 1);
        step("unm idle", 1, 0);

        // Back-to-back unmapped NONSEQs
        addr_phase(32'h8000_0000, NSEQ);
        step("b2b addr1", 1, 0);
        addr_phase(32'hF000_0000, NSEQ);
        step("b2b a.err1", 0, 1);
        step("b2b a.err2", 1, 1);
        no_transfer();
        step("b2b b.err1", 0, 1);
        step("b2b b.err2", 1, 1);
        step("b2b idle", 1, 0);

        // Unmapped IDLE and BUSY get zero-wait OKAY, then s3
        addr_phase(32'h7000_0000, IDLE);
        step("idle unm", 1, 0);
        addr_phase(32'hA000_0000, BUSY);
        step("busy unm", 1, 0);
        addr_phase(32'h3000_0000, NSEQ);
        t_rdata[3] = 32'h3333_0003;
        step("s3 addr", 1, 0);
        no_transfer();
        step("s3 data", 1, 0);

        // Illegal multi-select: lowest index wins
        t_hsel   = 7'b101_0100;
        t_htrans = NSEQ;
        t_rdata[2] = 32'h0202_0202;
        t_rdata[4] = 32'h0404_0404;
        step("multi addr", 1, 0);
        no_transfer();
        step("multi data", 1, 0);

        // Asynchronous reset in the middle of the first ERROR cycle
        addr_phase(32'hB000_0000, NSEQ);
        step("rst addr", 1, 0);
        no_transfer();
        #2 HRESETn = 1'b0;
        #1;
        check("async rst HREADY", {31'd0, bus.HREADY}, 32'd1);
        check("async rst HRESP",  {31'd0, bus.HRESP},  32'd0);
        check("async rst HRDATA", bus.HRDATA, DEF);
        m_owner = 7;
        m_phase = 0;
        #1 HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        addr_phase(32'hC000_0000, NSEQ);
        step("post rst addr", 1, 0);
        no_transfer();
        step("post rst err1", 0, 1);
        step("post rst err2", 1, 1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0:       t_hsel = '0;
                1:       t_hsel = 7'($urandom);
                default: t_hsel = decode({$urandom_range(0, 15) >> 0, 28'd0} >> 0 == 0 ? 32'd0 : 32'($urandom_range(0, 15)) << 28);
            endcase
            t_htrans = 2'($urandom);
            for (int i = 0; i < 7; i++) begin
                t_rdata[i] = $urandom;
                t_rdy[i]   = ($urandom_range(0, 3) != 0);
                t_resp[i]  = ($urandom_range(0, 4) == 0);
            end
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
